// File: rtl/fmm_row_match_scanner.sv
// Row-scan engine: walks one column of a row-major matrix in RAM and reports the
// first matching row, the last matching row, or the match count.
module fmm_row_match_scanner #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned ROW_STRIDE = 320,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic [1:0]        mode,
  input  logic [30:0]       start_row,
  input  logic [31:0]       num_rows,
  input  logic [ADDR_W-1:0] col_base,
  input  logic [DATA_W-1:0] match_val,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ce,
  input  logic [DATA_W-1:0] mem_q,
  output logic [31:0]       result_row,
  output logic [CNT_W-1:0]  match_count,
  output logic              result_vld
);

  localparam int unsigned ROW_W = 31;
  localparam int unsigned TAG_W = MEM_LAT * ROW_W;
  localparam logic [ADDR_W-1:0]  STRIDE_A = ADDR_W'(ROW_STRIDE);
  // Tag stages ahead of the head; a tag here means a read is still in flight.
  localparam logic [MEM_LAT-1:0] MID_MASK = ~(MEM_LAT'(1) << (MEM_LAT - 1));

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [31:0]        num_q, num_d;
  logic [DATA_W-1:0]  match_q, match_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               mem_ce_d;
  logic [ADDR_W-1:0]  mem_addr_d;
  logic [ROW_W-1:0]   iss_row, iss_row_d;
  logic [MEM_LAT-1:0] tag_vld, tag_vld_d;
  logic [TAG_W-1:0]   tag_rows, tag_rows_d;
  logic [31:0]        result_row_d;
  logic [CNT_W-1:0]   match_count_d;
  logic               done_q, done_d;

  logic [ADDR_W-1:0]  start_addr;
  logic [ROW_W-1:0]   head_row;
  logic               range_empty, can_issue, head_hit, first_mode, in_flight;

  assign start_addr  = col_base + ADDR_W'(start_row) * STRIDE_A;
  assign range_empty = $signed(num_rows) <= $signed({1'b0, start_row});
  assign can_issue   = $signed({1'b0, row_q}) < $signed(num_q);
  assign head_row    = tag_rows[TAG_W-1 -: ROW_W];
  assign head_hit    = tag_vld[MEM_LAT-1] && (mem_q == match_q);
  assign first_mode  = (mode_q == 2'd0) || (mode_q == 2'd3);
  assign in_flight   = mem_ce || (|(tag_vld & MID_MASK));

  assign ap_done    = done_q;
  assign ap_ready   = done_q;
  assign result_vld = done_q;
  assign ap_idle    = (state == ST_IDLE) && !ap_start;

  // Next-state, issue and compare logic
  always_comb begin
    state_d       = state;
    mode_d        = mode_q;
    num_d         = num_q;
    match_d       = match_q;
    row_d         = row_q;
    addr_d        = addr_q;
    mem_ce_d      = 1'b0;
    mem_addr_d    = mem_addr;
    iss_row_d     = iss_row;
    tag_vld_d     = (tag_vld << 1) | MEM_LAT'(mem_ce);
    tag_rows_d    = (tag_rows << ROW_W) | TAG_W'(iss_row);
    result_row_d  = result_row;
    match_count_d = match_count;
    done_d        = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (ap_start) begin
          mode_d        = mode;
          num_d         = num_rows;
          match_d       = match_val;
          result_row_d  = '1;
          match_count_d = '0;
          if (range_empty) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d    = ST_SCAN;
            mem_ce_d   = 1'b1;
            mem_addr_d = start_addr;
            iss_row_d  = start_row;
            row_d      = start_row + ROW_W'(1);
            addr_d     = start_addr + STRIDE_A;
          end
        end
      end
      ST_SCAN: begin
        if (head_hit && first_mode) begin
          // Early stop: drop every read still in flight
          result_row_d  = 32'(head_row);
          match_count_d = CNT_W'(1);
          tag_vld_d     = '0;
          state_d       = ST_DONE;
          done_d        = 1'b1;
        end else begin
          if (head_hit) begin
            result_row_d = 32'(head_row);
            if (!(&match_count)) match_count_d = match_count + CNT_W'(1);
          end
          if (can_issue) begin
            mem_ce_d   = 1'b1;
            mem_addr_d = addr_q;
            iss_row_d  = row_q;
            row_d      = row_q + ROW_W'(1);
            addr_d     = addr_q + STRIDE_A;
          end else if (!in_flight) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state       <= ST_IDLE;
      mode_q      <= '0;
      num_q       <= '0;
      match_q     <= '0;
      row_q       <= '0;
      addr_q      <= '0;
      mem_ce      <= 1'b0;
      mem_addr    <= '0;
      iss_row     <= '0;
      tag_vld     <= '0;
      tag_rows    <= '0;
      result_row  <= '1;
      match_count <= '0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_d;
      mode_q      <= mode_d;
      num_q       <= num_d;
      match_q     <= match_d;
      row_q       <= row_d;
      addr_q      <= addr_d;
      mem_ce      <= mem_ce_d;
      mem_addr    <= mem_addr_d;
      iss_row     <= iss_row_d;
      tag_vld     <= tag_vld_d;
      tag_rows    <= tag_rows_d;
      result_row  <= result_row_d;
      match_count <= match_count_d;
      done_q      <= done_d;
    end
  end

endmodule
